// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM32 control unit.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP   = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // nzcv is ordered {N, Z, C, V}; cond 1111 never executes.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, res;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = !z;
      COND_CS: res = c;
      COND_CC: res = !c;
      COND_MI: res = n;
      COND_PL: res = !n;
      COND_VS: res = v;
      COND_VC: res = !v;
      COND_HI: res = c && !z;
      COND_LS: res = !c || z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = !z && (n == v);
      COND_LE: res = z || (n != v);
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle. MemReady exists only when MC_MEM_READY_EN is defined.
interface mc_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
`ifdef MC_MEM_READY_EN
  logic        MemReady;
`endif
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUControl;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ImmSrc;
  logic        RegWrite;
  logic [1:0]  RegSrc;

`ifdef MC_MEM_READY_EN
  modport master (
    input  Instr, ALUFlags, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
           ALUSrcA, ALUSrcB, ImmSrc, RegWrite, RegSrc
  );
  modport slave (
    output Instr, ALUFlags, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
           ALUSrcA, ALUSrcB, ImmSrc, RegWrite, RegSrc
  );
`else
  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
           ALUSrcA, ALUSrcB, ImmSrc, RegWrite, RegSrc
  );
  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
           ALUSrcA, ALUSrcB, ImmSrc, RegWrite, RegSrc
  );
`endif
endinterface

// File: rtl/mc_condcheck.sv
// NZCV flag register, condition evaluation and condition-gated flag writes.
module mc_condcheck
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_wr,   // [1] = NZ, [0] = CV
  input  logic       hold,
  input  logic       use_held,
  output logic       cond_ex
);

  logic [3:0] flags;
  logic       cond_now;
  logic       cond_held;

  assign cond_now = cond_eval(cond, flags);
  // The writeback cycle after EXEC must see the condition from before its own flag update.
  assign cond_ex  = use_held ? cond_held : cond_now;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags     <= 4'b0000;
      cond_held <= 1'b0;
    end else begin
      if (hold) cond_held <= cond_now;
      if (cond_now && flag_wr[1]) flags[3:2] <= alu_flags[3:2];
      if (cond_now && flag_wr[0]) flags[1:0] <= alu_flags[1:0];
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM32 control unit: Moore main FSM, ALU decode, condition-gated writes.
// Defining MC_MEM_READY_EN adds MemReady stalls in FETCH, MEMRD and MEMWR.
module mc_controller
  import mc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mc_if.master bus
);

  state_t     state, state_nx;
  logic [1:0] op;
  logic       i_bit, s_bit;
  logic [3:0] cmd, rd;
  logic       mem_ready;
  logic       cond_ex;
  logic       exec;
  logic [1:0] flag_wr;
  logic [1:0] alu_dec;
  logic       alu_known;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
  logic [1:0] result_src, alu_control, alu_src_b;

  assign op    = bus.Instr[15:14];
  assign i_bit = bus.Instr[13];
  assign cmd   = bus.Instr[12:9];
  assign s_bit = bus.Instr[8];
  assign rd    = bus.Instr[3:0];

  logic unused_rn;
  assign unused_rn = ^bus.Instr[7:4];

`ifdef MC_MEM_READY_EN
  assign mem_ready = bus.MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  always_comb begin
    alu_dec   = ALU_ADD;
    alu_known = 1'b1;
    case (cmd)
      CMD_ADD: alu_dec = ALU_ADD;
      CMD_SUB: alu_dec = ALU_SUB;
      CMD_AND: alu_dec = ALU_AND;
      CMD_ORR: alu_dec = ALU_ORR;
      default: alu_known = 1'b0;
    endcase
  end

  assign exec    = (state == S_EXECR) || (state == S_EXECI);
  // Logical ops leave C and V alone; unrecognised commands never touch flags.
  assign flag_wr = (exec && s_bit && alu_known)
                 ? {1'b1, (alu_dec == ALU_ADD) || (alu_dec == ALU_SUB)} : 2'b00;

  mc_condcheck u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (bus.Instr[19:16]),
    .alu_flags (bus.ALUFlags),
    .flag_wr   (flag_wr),
    .hold      (exec),
    .use_held  (state == S_ALUWB),
    .cond_ex   (cond_ex)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_control = ALU_ADD;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RD2;
    case (state)
      S_FETCH: begin
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (mem_ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        case (op)
          OP_MEM:  state_nx = S_MEMADR;
          OP_DP:   state_nx = i_bit ? S_EXECI : S_EXECR;
          OP_BR:   state_nx = S_BRANCH;
          default: state_nx = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_b = SRCB_IMM;
        state_nx  = s_bit ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        if (mem_ready) state_nx = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = cond_ex;
        state_nx   = S_FETCH;
      end
      S_MEMWR: begin
        adr_src   = 1'b1;
        mem_write = cond_ex;
        if (mem_ready) state_nx = S_FETCH;
      end
      S_EXECR: begin
        alu_control = alu_dec;
        state_nx    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_b   = SRCB_IMM;
        alu_control = alu_dec;
        state_nx    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = cond_ex;
        pc_write  = cond_ex && (rd == 4'd15);
        state_nx  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        pc_write   = cond_ex;
        state_nx   = S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase
  end

  // Write enables are forced low for the whole reset pulse, not just after the edge.
  assign bus.PCWrite    = pc_write  & ~reset;
  assign bus.IRWrite    = ir_write  & ~reset;
  assign bus.MemWrite   = mem_write & ~reset;
  assign bus.RegWrite   = reg_write & ~reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUControl = alu_control;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed test-plan cases plus random instructions
// against an instruction-level reference model.
module tb_mc_controller;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] aluc;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] imm;
    logic       regw;
    logic [1:0] regsrc;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  mc_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [3:0] flags_m;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic ctl_t obs_ctl();
    return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
            bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegWrite, bus.RegSrc};
  endfunction

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;           4'h1: return !z;
      4'h2: return cy;          4'h3: return !cy;
      4'h4: return n;           4'h5: return !n;
      4'h6: return v;           4'h7: return !v;
      4'h8: return cy && !z;    4'h9: return !cy || z;
      4'hA: return n == v;      4'hB: return n != v;
      4'hC: return !z && n == v; 4'hD: return z || n != v;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int instr_len(input logic [19:0] ins);
    case (ins[15:14])
      2'b00:   return 4;
      2'b01:   return ins[8] ? 5 : 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0010: return 2'b01;
      4'b0000: return 2'b10;
      4'b1100: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Expected controls for cycle k of an instruction; m marks the fields that matter.
  function automatic ctl_t expect_ctl(input logic [19:0] ins, input bit ok, input int k,
                                      output ctl_t m);
    ctl_t e;
    logic [1:0] op;
    op = ins[15:14];
    e = '0;
    m = '1;
    e.imm = op;
    e.regsrc = {op == 2'b01, op == 2'b10};
    if (k == 0) begin
      e.pcw = 1; e.irw = 1; e.srca = 1; e.srcb = 2'b10; e.res = 2'b10;
    end else if (k == 1) begin
      e.srca = 1; e.srcb = 2'b10; e.res = 2'b10; m.adr = 0;
    end else if (op == 2'b01) begin
      if (k == 2) begin
        e.srcb = 2'b01; m.res = 0; m.adr = 0;
      end else begin
        m.aluc = 0; m.srca = 0; m.srcb = 0;
        if (ins[8] && k == 3) begin e.adr = 1; end
        else if (ins[8]) begin e.res = 2'b01; e.regw = ok; m.adr = 0; end
        else begin e.adr = 1; e.memw = ok; end
      end
    end else if (op == 2'b00) begin
      if (k == 2) begin
        e.srcb = ins[13] ? 2'b01 : 2'b00; e.aluc = alu_of(ins[12:9]); m.res = 0; m.adr = 0;
      end else begin
        e.regw = ok; e.pcw = ok && (ins[3:0] == 4'd15);
        m.adr = 0; m.aluc = 0; m.srca = 0; m.srcb = 0;
      end
    end else begin
      e.srcb = 2'b01; e.res = 2'b10; e.pcw = ok; m.adr = 0;
    end
    return e;
  endfunction

  // Entry and exit: 1 time unit after a rising edge with the controller in FETCH.
  task automatic run_instr(input logic [19:0] ins, input logic [3:0] af, input string tag);
    bit ok;
    int len;
    ctl_t e, m;
    ok = cond_ok(ins[19:16], flags_m);
    len = instr_len(ins);
    bus.Instr = ins;
    bus.ALUFlags = af;
    for (int k = 0; k < len; k++) begin
      #1;
      e = expect_ctl(ins, ok, k, m);
      check_val($sformatf("%s c%0d ins=%05h", tag, k, ins), 32'(obs_ctl() & m), 32'(e & m));
      @(posedge clk);
      #1;
    end
    if (ins[15:14] == 2'b00 && ins[8] && ok) begin
      case (ins[12:9])
        4'b0100, 4'b0010: flags_m = af;
        4'b0000, 4'b1100: flags_m[3:2] = af[3:2];
        default: ;
      endcase
    end
    check_val($sformatf("%s flags", tag), 32'(dut.u_cond.flags), 32'(flags_m));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    ctl_t e, m;
    logic [19:0] ins;
    reset = 1'b1;
    bus.Instr = '0;
    bus.ALUFlags = '0;
`ifdef MC_MEM_READY_EN
    bus.MemReady = 1'b1;
`endif
    flags_m = 4'b0000;
    #12;
    e = expect_ctl(20'h0, 1'b1, 0, m);
    e.pcw = 0; e.irw = 0;
    check_val("reset outputs", 32'(obs_ctl() & m), 32'(e & m));
    check_val("reset flags", 32'(dut.u_cond.flags), 32'(4'b0000));
    @(posedge clk);
    #1 reset = 1'b0;

    run_instr({4'hE, 2'b00, 1'b0, 4'b0100, 1'b0, 4'd2, 4'd1}, 4'b1111, "add");
    run_instr({4'hE, 2'b00, 1'b0, 4'b0010, 1'b1, 4'd2, 4'd1}, 4'b0100, "subs");
    run_instr({4'h0, 2'b10, 14'h0123}, 4'b0000, "beq");
    run_instr({4'h1, 2'b10, 14'h0456}, 4'b0000, "bne");
    run_instr({4'hE, 2'b01, 6'b011001, 4'd2, 4'd3}, 4'b0000, "ldr");
    run_instr({4'hE, 2'b01, 6'b011000, 4'd2, 4'd3}, 4'b0000, "str");
    run_instr({4'h1, 2'b00, 1'b1, 4'b0000, 1'b1, 4'd2, 4'd4}, 4'b1011, "ands_ne");
    run_instr({4'hE, 2'b00, 1'b1, 4'b1100, 1'b1, 4'd2, 4'd15}, 4'b1011, "orrs_pc");
    run_instr({4'hE, 2'b00, 1'b0, 4'b1010, 1'b1, 4'd2, 4'd5}, 4'b0110, "cmd_other");
    run_instr({4'hE, 2'b11, 14'h0000}, 4'b0000, "op11");
    run_instr({4'hF, 2'b00, 1'b0, 4'b0100, 1'b1, 4'd2, 4'd5}, 4'b0101, "nv");

    for (int i = 0; i < 300; i++)
      run_instr(20'($urandom), 4'($urandom), "rnd");

    // Reset in the middle of a store, with flags nonzero beforehand.
    run_instr({4'hE, 2'b00, 1'b0, 4'b0010, 1'b1, 4'd2, 4'd1}, 4'b1010, "subs_pre");
    ins = {4'hE, 2'b01, 6'b000000, 4'd2, 4'd3};
    bus.Instr = ins;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
    end
    #1;
    check_val("str memwr memwrite", 32'(bus.MemWrite), 32'(1));
    #1 reset = 1'b1;
    #1;
    e = expect_ctl(ins, 1'b1, 0, m);
    e.pcw = 0; e.irw = 0;
    check_val("mid reset outputs", 32'(obs_ctl() & m), 32'(e & m));
    check_val("mid reset memwrite", 32'(bus.MemWrite), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    flags_m = 4'b0000;
    check_val("post reset flags", 32'(dut.u_cond.flags), 32'(4'b0000));
    run_instr({4'h0, 2'b10, 14'h0777}, 4'b0000, "beq_after_rst");
    run_instr({4'hE, 2'b01, 6'b000001, 4'd2, 4'd3}, 4'b0000, "ldr_after_rst");

`ifdef MC_MEM_READY_EN
    ins = {4'hE, 2'b11, 14'h0000};
    bus.Instr = ins;
    bus.MemReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      e = expect_ctl(ins, 1'b1, 0, m);
      e.pcw = 0; e.irw = 0;
      check_val($sformatf("stall fetch %0d", k), 32'(obs_ctl() & m), 32'(e & m));
      @(posedge clk);
      #1;
    end
    bus.MemReady = 1'b1;
    #1;
    e = expect_ctl(ins, 1'b1, 0, m);
    check_val("ready fetch", 32'(obs_ctl() & m), 32'(e & m));
    @(posedge clk);
    #1;
    e = expect_ctl(ins, 1'b1, 1, m);
    check_val("decode after stall", 32'(obs_ctl() & m), 32'(e & m));
    @(posedge clk);
    #1;
    run_instr({4'hE, 2'b00, 1'b0, 4'b0100, 1'b0, 4'd2, 4'd1}, 4'b0000, "add_after_stall");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the ARM32 core. It sequences one shared ALU and one unified instruction/data memory across 3–5 cycles per instruction using a Moore main FSM. It also holds the NZCV flag register and gates every architectural write with the instruction's condition field. It sits beside the multicycle datapath, driving its mux selects and write enables from the registered instruction.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- Instr  in  20  Instr[31:12] from instruction register: cond, op, funct, Rd
- ALUFlags  in  4  N,Z,C,V from ALU, current cycle
- MemReady  in  1  memory ready (present only with MC_MEM_READY_EN)
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=Result
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register enable
- ResultSrc  out  2  00=ALUOut reg, 01=Data reg, 10=ALUResult
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ALUSrcA  out  1  0=RD1 reg, 1=PC
- ALUSrcB  out  2  00=RD2 reg, 01=ExtImm, 10=constant 4
- ImmSrc  out  2  equals Instr[27:26]
- RegWrite  out  1  register file write enable
- RegSrc  out  2  [0]=op==10 (read R15), [1]=op==01 (read Rd as RA2)

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. Next state by op:
  - op=01 → MEMADR.
  - op=00 with I=0 → EXECR; with I=1 → EXECI.
  - op=10 → BRANCH.
  - op=11 → FETCH, with no writes.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Next state is MEMRD if L (funct[0]) else MEMWR.
- MEMRD: ResultSrc=00, AdrSrc=1 → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx → FETCH.
- MEMWR: ResultSrc=00, AdrSrc=1, MemWrite=CondEx → FETCH.
- EXECR uses ALUSrcB=00; EXECI uses ALUSrcB=01. Both use ALUSrcA=0, ALU-decoded op, and go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=CondEx. PCWrite=CondEx when Rd==15. Next state is FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx → FETCH.
- ALU decode (funct[4:1]), used in EXECR/EXECI only:
  - 0100 → ADD, 0010 → SUB, 0000 → AND, 1100 → ORR.
  - Any other cmd → ADD with no flag update.
- Flag write:
  - With S=1, ADD/SUB write NZCV; AND/ORR write NZ only.
  - The write occurs at the end of EXECR/EXECI, from ALUFlags, only when CondEx=1.
- CondEx is combinational from Instr[31:28] and the stored flags:
  - EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE per ARM.
  - 1110 (AL) → 1; 1111 → 0.
- A failed condition suppresses RegWrite, MemWrite, the PCWrite in BRANCH/ALUWB, and the flag update. The state path is unchanged.

## Timing
- State register and flags update on posedge clk. Reset clears both asynchronously: state=FETCH, flags=0000.
- While reset is high, PCWrite, IRWrite, MemWrite, RegWrite = 0. The other outputs show FETCH values.
- Outputs are Moore (state plus Instr/flags), with no registered output stage.
- Instruction latency in cycles:
  - Branch: 3.
  - Data-processing: 4.
  - STR: 4.
  - LDR: 5.
  - op=11: 2.
- Flags written in EXEC* are visible to the next instruction's CondEx, never to the current one.
- Reset asserted mid-instruction: the instruction is abandoned, no partial write follows, and fetch restarts after deassertion.

## Configuration
- MC_MEM_READY_EN defined:
  - MemReady port is present.
  - FETCH, MEMRD and MEMWR hold their state while MemReady=0.
  - In FETCH, IRWrite and PCWrite are asserted only in the cycle MemReady=1.
  - In MEMWR, MemWrite stays asserted (if CondEx) every held cycle.
- Undefined: no port; memory is single-cycle and the behaviour above applies.

## Structure
- Package mc_pkg holds:
  - State enum.
  - ALUSrcB, ResultSrc and ALUControl encodings.
  - Cond-code and cmd constants.
- Sub-module mc_condcheck holds the flag register, CondEx evaluation and flag-write gating. The FSM and ALU decode stay in mc_controller.

## Test plan
- ADD R1,R2,R3 (cond 1110, S=0): state path FETCH→DECODE→EXECR→ALUWB→FETCH. RegWrite=1 only in ALUWB, ALUControl=00 in EXECR.
- SUBS with ALUFlags=0100, then BEQ: flags become 0100 and the BRANCH cycle has PCWrite=1. Repeat with BNE: PCWrite=0 in BRANCH.
- LDR: 5 cycles; AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB. STR: MemWrite=1 in MEMWR only.
- ANDS with cond 0001 (NE) and Z=1: no RegWrite, flags unchanged, FETCH on cycle 5.
- Reset asserted in MEMWR: MemWrite drops to 0 immediately, state=FETCH, flags=0000 after release.
- With MC_MEM_READY_EN, MemReady low for 3 cycles in FETCH: state holds, IRWrite=PCWrite=0 until the ready cycle, then DECODE.
